delay_frame_gen: RTL and testbench
==================================

// Module: delay_frame_gen
// PURPOSE
//  Transmit-side counterpart of the RX frame catcher in the delay tester. Generates
//  periodic Ethernet test frames carrying a sequence number and departure timestamp,
//  and drives them into the MAC client TX interface.
//  The MAC TX path shares rx_clk, so no clock crossing is needed.
//  Also drives the MAC TX configuration pins.
// PARAMETERS
//  FRAME_LEN  64             bytes per frame excl. FCS; legal range 20..1500
//  GAP_CYCLES 1000           min idle cycles between frames (dvld low); 0 treated as 1
//  DST_MAC    48'hFFFFFFFFFFFF destination address, sent MSB byte first
//  SRC_MAC    48'h000A35000001 source address, sent MSB byte first
//  ETHERTYPE  16'h88B5       EtherType field
// PORTS
//  rx_clk             in   1   clock, all logic on posedge
//  reset              in   1   reset, asynchronous, active-high
//  gen_en             in   1   level; 1 = keep generating frames
//  conf_tx_en         out  1   MAC TX enable
//  conf_tx_no_gen_crc out  1   1 = MAC must not append FCS
//  conf_tx_jumbo_en   out  1   MAC jumbo enable (always 0)
//  mac_tx_data        out  8   TX byte
//  mac_tx_dvld        out  1   TX data valid
//  mac_tx_ack         in   1   MAC accepted byte 0; 1-cycle pulse
//  tx_seq             out  16  sequence number of the last completed frame
//  tx_timestamp       out  32  timestamp carried in the last completed frame
//  frame_sent         out  1   1-cycle pulse on the cycle after the last byte
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; state RESET; seq counter 0; timestamp counter 0.
//   - conf_tx_en goes to 1 on the first clock after reset release; stays 1.
//  Timestamp: ts_cnt, 32-bit, free-running, +1 every cycle, wraps 0xFFFFFFFF->0.
//  FSM (4-bit encoding; RESET=15):
//   - RESET -> IDLE, unconditionally.
//   - IDLE -> WAIT_ACK when gen_en=1. Latch seq and ts_cnt into the frame header regs.
//   - WAIT_ACK: dvld=1, data=byte0, both held until mac_tx_ack=1 -> DATA.
//     byte_cnt=1 on the next cycle.
//   - DATA: one byte per cycle, no stalls.
//     -> GAP after the last byte; dvld=0 on the following cycle.
//   - GAP: count GAP_CYCLES cycles with dvld=0, then:
//     -> WAIT_ACK if gen_en=1, else -> IDLE.
//  Frame layout (byte index):
//   - 0-5 DST_MAC; 6-11 SRC_MAC; 12-13 ETHERTYPE.
//   - 14-15 seq, MSB first; 16-19 latched timestamp, MSB first.
//   - 20..FRAME_LEN-1: byte = index[7:0].
//  On completion (first GAP cycle):
//   - frame_sent pulses.
//   - tx_seq/tx_timestamp update to the sent values.
//   - seq += 1, wrapping 0xFFFF->0.
//  Boundary conditions:
//   - gen_en falling mid-frame or in WAIT_ACK: current frame completes normally.
//   - mac_tx_ack outside WAIT_ACK: ignored.
//   - Reset mid-frame: dvld drops asynchronously; frame abandoned; seq restarts at 0.
//   - byte_cnt wide enough for FRAME_LEN+4; no wrap inside a frame.
// CONFIGURATION
//  Macro FRAME_GEN_FCS_EN.
//   - Defined:
//     - conf_tx_no_gen_crc=1.
//     - Internal CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, final XOR)
//       computed over bytes 0..FRAME_LEN-1.
//     - 4 FCS bytes appended LSB first; dvld spans FRAME_LEN+4 bytes.
//   - Undefined:
//     - conf_tx_no_gen_crc=0; MAC appends FCS.
//     - dvld spans FRAME_LEN bytes; no CRC logic present.
// TESTING
//  - Reset state: reset pulse with gen_en=0 -> all outputs 0.
//    conf_tx_en=1 one clock after release; dvld stays 0.
//  - Single frame: gen_en=1, ack 3 cycles after dvld rises -> byte0=0xFF held until ack.
//    64 bytes total with no stalls; bytes 12-13 = 88 B5; bytes 14-15 = 00 00.
//    frame_sent pulses; tx_seq=0.
//  - Gap/sequence: gen_en held 1, GAP_CYCLES=10 -> exactly 10 idle cycles between frames.
//    Second frame seq = 00 01; timestamp delta = frame duration + gap + ack wait.
//  - Seq wrap: force seq to 0xFFFF -> frame carries FF FF; next frame carries 00 00.
//  - Mid-frame events: gen_en=0 at byte 30 -> frame completes, then IDLE.
//    Reset at byte 30 -> dvld 0 immediately; next frame seq=0.
//  - FCS_EN: FRAME_LEN=60 -> 64 bytes on the wire; FCS matches reference CRC model.
//    conf_tx_no_gen_crc=1.

Source files
------------

// File: rtl/delay_frame_gen.sv
// ---------------------------------------------------------------------------
// delay_frame_gen
//
// Transmit-side test frame generator for the delay tester. While gen_en is
// high it emits periodic Ethernet frames into the MAC client TX interface.
// Each frame carries a 16-bit sequence number and a 32-bit departure
// timestamp. The MAC TX path runs on rx_clk, so no clock crossing is needed.
//
// Frame layout (byte index):
//   0-5   DST_MAC, MSB first       6-11  SRC_MAC, MSB first
//   12-13 ETHERTYPE               14-15 sequence number, MSB first
//   16-19 timestamp, MSB first    20..FRAME_LEN-1  low byte of the index
//   FRAME_LEN..+3  FCS, LSB first (FRAME_GEN_FCS_EN builds only)
//
// Optional feature macro: FRAME_GEN_FCS_EN
//   defined   : CRC-32 is computed internally and appended;
//               conf_tx_no_gen_crc = 1
//   undefined : the MAC appends the FCS; conf_tx_no_gen_crc = 0
//
// Ports
//   rx_clk             in   clock, everything on posedge
//   reset              in   asynchronous, active-high reset
//   gen_en             in   level, 1 = keep generating frames
//   conf_tx_en         out  MAC TX enable, 1 from the first clock after reset
//   conf_tx_no_gen_crc out  1 = MAC must not append an FCS
//   conf_tx_jumbo_en   out  MAC jumbo enable, always 0
//   mac_tx_data        out  TX byte
//   mac_tx_dvld        out  TX data valid
//   mac_tx_ack         in   MAC accepted byte 0 (1-cycle pulse)
//   tx_seq             out  sequence number of the last completed frame
//   tx_timestamp       out  timestamp carried in the last completed frame
//   frame_sent         out  1-cycle pulse on the cycle after the last byte
// ---------------------------------------------------------------------------
module delay_frame_gen #(
    parameter int          FRAME_LEN  = 64,
    parameter int          GAP_CYCLES = 1000,
    parameter logic [47:0] DST_MAC    = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC    = 48'h000A35000001,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic        gen_en,
    output logic        conf_tx_en,
    output logic        conf_tx_no_gen_crc,
    output logic        conf_tx_jumbo_en,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_dvld,
    input  logic        mac_tx_ack,
    output logic [15:0] tx_seq,
    output logic [31:0] tx_timestamp,
    output logic        frame_sent
);

`ifdef FRAME_GEN_FCS_EN
    localparam int   FCS_BYTES  = 4;
    localparam logic NO_GEN_CRC = 1'b1;
`else
    localparam int   FCS_BYTES  = 0;
    localparam logic NO_GEN_CRC = 1'b0;
`endif

    localparam int TOTAL   = FRAME_LEN + FCS_BYTES;
    localparam int CNT_W   = $clog2(TOTAL + 1);
    // A zero gap would let dvld stay high between frames; one idle cycle minimum.
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GAP_W   = $clog2(GAP_EFF + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WAIT_ACK = 4'd1,
        ST_DATA     = 4'd2,
        ST_GAP      = 4'd3,
        ST_RESET    = 4'd15
    } state_t;

    state_t           state;
    logic [15:0]      seq_cnt;
    logic [31:0]      ts_cnt;
    logic [15:0]      hdr_seq;
    logic [31:0]      hdr_ts;
    logic [CNT_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      fcs;
    logic [7:0]       next_byte;
    logic             start;

    // Byte at position idx of the frame currently being sent.
    function automatic logic [7:0] frame_byte(input int idx, input logic [15:0] seq,
                                              input logic [31:0] ts, input logic [31:0] crc_out);
        logic [159:0] hdr;
        hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq, ts};
        if (idx < 20)
            return hdr[8*(19-idx) +: 8];
        else if (idx < FRAME_LEN)
            return idx[7:0];
        else
            return crc_out[8*(idx-FRAME_LEN) +: 8];
    endfunction

`ifdef FRAME_GEN_FCS_EN
    localparam logic [CNT_W-1:0] FL_IDX = CNT_W'(FRAME_LEN);

    logic [31:0] crc_reg;
    logic [31:0] crc_cur;

    // Reflected CRC-32 (0x04C11DB7 reversed), one byte LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // The byte on the bus is folded in combinationally so the first FCS byte
    // can be produced while the last payload byte is still being presented.
    always_comb begin
        crc_cur = crc_reg;
        if (byte_cnt < FL_IDX)
            crc_cur = crc_byte(crc_reg, mac_tx_data);
    end

    assign fcs = ~crc_cur;
`else
    assign fcs = '0;
`endif

    assign next_byte        = frame_byte(int'(byte_cnt) + 1, hdr_seq, hdr_ts, fcs);
    assign start            = gen_en && ((state == ST_IDLE) ||
                                         ((state == ST_GAP) && (gap_cnt == GAP_LAST)));
    assign conf_tx_jumbo_en = 1'b0;

    // NOTE: async reset puts dvld low immediately, abandoning any frame in flight.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state              <= ST_RESET;
            seq_cnt            <= '0;
            ts_cnt             <= '0;
            hdr_seq            <= '0;
            hdr_ts             <= '0;
            byte_cnt           <= '0;
            gap_cnt            <= '0;
            conf_tx_en         <= 1'b0;
            conf_tx_no_gen_crc <= 1'b0;
            mac_tx_data        <= '0;
            mac_tx_dvld        <= 1'b0;
            tx_seq             <= '0;
            tx_timestamp       <= '0;
            frame_sent         <= 1'b0;
`ifdef FRAME_GEN_FCS_EN
            crc_reg            <= '1;
`endif
        end else begin
            // NOTE: non-blocking assignments: every read below sees pre-edge values.
            ts_cnt             <= ts_cnt + 32'd1;
            conf_tx_en         <= 1'b1;
            conf_tx_no_gen_crc <= NO_GEN_CRC;
            frame_sent         <= 1'b0;

            case (state)
                ST_RESET: state <= ST_IDLE;
                ST_IDLE:  if (gen_en) state <= ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (mac_tx_ack) begin
                        state       <= ST_DATA;
                        byte_cnt    <= CNT_ONE;
                        mac_tx_data <= next_byte;
`ifdef FRAME_GEN_FCS_EN
                        crc_reg     <= crc_cur;
`endif
                    end
                end
                ST_DATA: begin
                    if (byte_cnt == LAST_IDX) begin
                        state        <= ST_GAP;
                        mac_tx_dvld  <= 1'b0;
                        mac_tx_data  <= '0;
                        gap_cnt      <= '0;
                        frame_sent   <= 1'b1;
                        tx_seq       <= hdr_seq;
                        tx_timestamp <= hdr_ts;
                        seq_cnt      <= seq_cnt + 16'd1;
                    end else begin
                        byte_cnt    <= byte_cnt + CNT_ONE;
                        mac_tx_data <= next_byte;
`ifdef FRAME_GEN_FCS_EN
                        crc_reg     <= crc_cur;
`endif
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= gen_en ? ST_WAIT_ACK : ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + GAP_ONE;
                end
                default: state <= ST_RESET;
            endcase

            // Frame setup shared by the IDLE and end-of-GAP entries to WAIT_ACK.
            if (start) begin
                hdr_seq     <= seq_cnt;
                hdr_ts      <= ts_cnt;
                byte_cnt    <= '0;
                mac_tx_dvld <= 1'b1;
                mac_tx_data <= DST_MAC[47:40];
`ifdef FRAME_GEN_FCS_EN
                crc_reg     <= '1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_delay_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_delay_frame_gen
//
// Self-checking bench for delay_frame_gen. Expected frames are rebuilt from
// the field layout (header concatenation, index bytes, MSB-first CRC-32 on
// bit-reversed data); the expected timestamp is the number of clocks since
// reset release at the cycle the frame starts. Build with FRAME_GEN_FCS_EN
// defined to exercise the internal FCS with a 60-byte frame.
// ---------------------------------------------------------------------------
module tb_delay_frame_gen;

`ifdef FRAME_GEN_FCS_EN
    localparam bit FCS_ON = 1'b1;
    localparam int FL     = 60;
`else
    localparam bit FCS_ON = 1'b0;
    localparam int FL     = 64;
`endif
    localparam int TOTAL    = FL + (FCS_ON ? 4 : 0);
    localparam int GAP      = 10;
    localparam int WAIT_MAX = GAP + 200;

    logic        rx_clk;
    logic        reset;
    logic        gen_en;
    logic        conf_tx_en;
    logic        conf_tx_no_gen_crc;
    logic        conf_tx_jumbo_en;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_dvld;
    logic        mac_tx_ack;
    logic [15:0] tx_seq;
    logic [31:0] tx_timestamp;
    logic        frame_sent;

    delay_frame_gen #(
        .FRAME_LEN  (FL),
        .GAP_CYCLES (GAP)
    ) dut (
        .rx_clk             (rx_clk),
        .reset              (reset),
        .gen_en             (gen_en),
        .conf_tx_en         (conf_tx_en),
        .conf_tx_no_gen_crc (conf_tx_no_gen_crc),
        .conf_tx_jumbo_en   (conf_tx_jumbo_en),
        .mac_tx_data        (mac_tx_data),
        .mac_tx_dvld        (mac_tx_dvld),
        .mac_tx_ack         (mac_tx_ack),
        .tx_seq             (tx_seq),
        .tx_timestamp       (tx_timestamp),
        .frame_sent         (frame_sent)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    // Clocks elapsed since reset release.
    logic [31:0] cyc;
    always @(posedge rx_clk or posedge reset) begin
        if (reset) cyc <= '0;
        else       cyc <= cyc + 32'd1;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    typedef struct {
        int          ack_delay;
        int          drop_at;
        logic [15:0] exp_seq;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] ts;
    logic [31:0] prev_ts;
    int          prev_ack;
    int          idle;
    bit          ok;
    logic [15:0] exp_s;
    bit          was_running;
    bit          seen;
    int          ad;
    int          drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] w);
        for (int i = 0; i < 32; i++) rev32[i] = w[31-i];
    endfunction

    // Expected wire bytes of one frame.
    task automatic build_expected(input logic [15:0] s, input logic [31:0] t);
        logic [159:0] hdr;
        logic [31:0]  crc;
        logic [7:0]   d;
        hdr = {48'hFFFFFFFFFFFF, 48'h000A35000001, 16'h88B5, s, t};
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(hdr[159-8*i -: 8]);
        for (int i = 20; i < FL; i++) exp_q.push_back(8'(i));
        if (FCS_ON) begin
            crc = 32'hFFFFFFFF;
            for (int k = 0; k < FL; k++) begin
                d = rev8(exp_q[k]);
                for (int j = 7; j >= 0; j--)
                    crc = (crc[31] ^ d[j]) ? ({crc[30:0], 1'b0} ^ 32'h04C11DB7) : {crc[30:0], 1'b0};
            end
            crc = ~rev32(crc);
            for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
        end
    endtask

    // Waits (bounded) for dvld, checks byte 0 is held, then acks after ack_delay cycles.
    task automatic start_frame(input int ack_delay, output logic [31:0] t, output int n_idle, output bit started);
        int  n    = 0;
        bit  held = 1'b1;
        while (!mac_tx_dvld && n < WAIT_MAX) begin
            @(negedge rx_clk);
            n++;
        end
        n_idle  = n;
        started = mac_tx_dvld;
        t       = cyc - 32'd1;
        got.delete();
        check("dvld_rise", mac_tx_dvld, 1'b1);
        if (!started) return;
        for (int i = 0; i < ack_delay; i++) begin
            if (mac_tx_dvld !== 1'b1 || mac_tx_data !== 8'hFF) held = 1'b0;
            @(negedge rx_clk);
        end
        check("byte0_hold", {held, mac_tx_dvld, mac_tx_data}, {1'b1, 1'b1, 8'hFF});
        got.push_back(mac_tx_data);
        mac_tx_ack = 1'b1;
        @(negedge rx_clk);
        mac_tx_ack = 1'b0;
    endtask

    // Collects bytes until dvld falls; optional gen_en drop and stray acks.
    task automatic collect(input int drop_at, input bit noise);
        bit early = 1'b0;
        while (mac_tx_dvld && got.size() < TOTAL + 8) begin
            if (got.size() == drop_at) gen_en = 1'b0;
            if (frame_sent) early = 1'b1;
            got.push_back(mac_tx_data);
            mac_tx_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge rx_clk);
        end
        mac_tx_ack = 1'b0;
        check("no_early_sent", early, 1'b0);
    endtask

    // Called on the first cycle after the last byte.
    task automatic finish_frame(input logic [15:0] s, input logic [31:0] t, input string tag);
        build_expected(s, t);
        check({tag, "_len"}, got.size(), exp_q.size());
        while (got.size() < exp_q.size()) got.push_back(8'h00);
        check({tag, "_sent"}, {mac_tx_dvld, frame_sent}, 2'b01);
        check({tag, "_tx_seq"}, tx_seq, s);
        check({tag, "_tx_ts"}, tx_timestamp, t);
        check({tag, "_ethertype"}, {got[12], got[13]}, 16'h88B5);
        check({tag, "_seq_field"}, {got[14], got[15]}, s);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
            if (got[i] !== exp_q[i]) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs = '{'{3, -1, 16'd0}, '{0, -1, 16'd1}, '{5, -1, 16'd2}, '{1, 30, 16'd3}};

        reset      = 1'b1;
        gen_en     = 1'b0;
        mac_tx_ack = 1'b0;
        repeat (3) @(negedge rx_clk);
        check("reset_outputs", {conf_tx_en, conf_tx_no_gen_crc, conf_tx_jumbo_en, mac_tx_data,
                                mac_tx_dvld, tx_seq, tx_timestamp, frame_sent}, '0);
        reset = 1'b0;
        #1;
        check("conf_tx_en_before_clk", conf_tx_en, 1'b0);
        @(negedge rx_clk);
        check("conf_after_release", {conf_tx_en, conf_tx_no_gen_crc, conf_tx_jumbo_en}, {1'b1, FCS_ON, 1'b0});
        repeat (5) @(negedge rx_clk);
        check("idle_no_dvld", {mac_tx_dvld, frame_sent}, 2'b00);

        // Back-to-back frames from the vector table; the last one drops gen_en at byte 30.
        gen_en   = 1'b1;
        prev_ts  = '0;
        prev_ack = 0;
        for (int i = 0; i < 4; i++) begin
            start_frame(vecs[i].ack_delay, ts, idle, ok);
            if (i > 0) begin
                check("tbl_gap", idle, GAP);
                check("tbl_ts_delta", ts - prev_ts, prev_ack + TOTAL + GAP);
            end
            collect(vecs[i].drop_at, 1'b0);
            finish_frame(vecs[i].exp_seq, ts, "tbl");
            prev_ts  = ts;
            prev_ack = vecs[i].ack_delay;
        end

        seen = 1'b0;
        repeat (GAP + 20) begin
            @(negedge rx_clk);
            if (mac_tx_dvld) seen = 1'b1;
        end
        check("stay_idle_after_drop", seen, 1'b0);

        // Sequence wrap.
        force dut.seq_cnt = 16'hFFFF;
        @(negedge rx_clk);
        release dut.seq_cnt;
        gen_en = 1'b1;
        start_frame(2, ts, idle, ok);
        collect(-1, 1'b0);
        finish_frame(16'hFFFF, ts, "wrap_a");
        start_frame(1, ts, idle, ok);
        check("wrap_gap", idle, GAP);
        collect(5, 1'b0);
        finish_frame(16'h0000, ts, "wrap_b");

        // Randomized frames: ack latency, stray acks during DATA, occasional gen_en drops.
        exp_s       = 16'd1;
        was_running = 1'b0;
        for (int r = 0; r < 16; r++) begin
            ad     = int'($urandom_range(0, 6));
            drop   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TOTAL - 2)) : -1;
            gen_en = 1'b1;
            start_frame(ad, ts, idle, ok);
            if (was_running) check("rnd_gap", idle, GAP);
            collect(drop, 1'b1);
            finish_frame(exp_s, ts, "rnd");
            exp_s       = exp_s + 16'd1;
            was_running = (drop < 0);
            if (drop >= 0) begin
                seen = 1'b0;
                repeat (GAP + int'($urandom_range(1, 5))) begin
                    @(negedge rx_clk);
                    if (mac_tx_dvld) seen = 1'b1;
                end
                check("rnd_idle_after_drop", seen, 1'b0);
            end
        end

        // Reset in the middle of a frame.
        gen_en = 1'b1;
        start_frame(3, ts, idle, ok);
        repeat (29) @(negedge rx_clk);
        check("byte30_before_reset", {mac_tx_dvld, mac_tx_data}, {1'b1, 8'd30});
        reset = 1'b1;
        #1;
        check("reset_mid_frame", {mac_tx_dvld, frame_sent, tx_seq, conf_tx_en}, '0);
        @(negedge rx_clk);
        reset = 1'b0;
        start_frame(0, ts, idle, ok);
        check("post_reset_ts", ts, 32'd1);
        collect(-1, 1'b0);
        finish_frame(16'h0000, ts, "post_reset");
        gen_en = 1'b0;

        repeat (5) @(negedge rx_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
